// File: rtl/bram_snap_ctrl.sv
// Snapshot capture controller for the fabric-side port of a shared dual-port BRAM.
// Arms on a rising edge of ctrl_arm, optionally waits for trig, then writes len words from address 0.
module bram_snap_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ctrl_arm,
  input  logic              ctrl_abort,
  input  logic              ctrl_trig_en,
  input  logic [ADDR_W:0]   ctrl_len,
  input  logic              trig,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_r;
  state_t              state_n_s;
  logic                arm_d_r;
  logic                arm_ok_r;
  logic                arm_pulse_s;
  logic                cap_s;
  logic                load_s;
  logic                last_s;
  logic [ADDR_W:0]     len_r;
  logic [ADDR_W:0]     len_sel_s;
  logic [ADDR_W:0]     wr_count_r;
  logic [ADDR_W-1:0]   addr_cnt_r;
  logic [ADDR_W-1:0]   bram_addr_r;
  logic [DATA_W-1:0]   bram_wr_data_r;
  logic                bram_we_r;
  logic                busy_r;
  logic                done_r;

  // arm_ok_r blocks an arm level held high across reset until it has been seen low.
  assign arm_pulse_s = ctrl_arm & ~arm_d_r & arm_ok_r;
  assign last_s      = ((wr_count_r + ONE_C) == len_r);

  // Length normalisation: 0 or anything beyond the depth means a full-depth capture.
  always_comb begin
    len_sel_s = ctrl_len;
    if ((ctrl_len == {(ADDR_W+1){1'b0}}) || (ctrl_len > DEPTH_C)) begin
      len_sel_s = DEPTH_C;
    end else begin
      len_sel_s = ctrl_len;
    end
  end

  // Next-state and capture/load strobes.
  always_comb begin
    state_n_s = state_r;
    cap_s     = 1'b0;
    load_s    = 1'b0;
    if (ctrl_abort) begin
      state_n_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (arm_pulse_s) begin
            load_s    = 1'b1;
            state_n_s = ctrl_trig_en ? ST_ARMED : ST_CAPTURE;
          end else begin
            state_n_s = state_r;
          end
        end
        ST_ARMED: begin
          if (trig) begin
            cap_s     = din_valid;
            state_n_s = (din_valid && last_s) ? ST_DONE : ST_CAPTURE;
          end else begin
            state_n_s = ST_ARMED;
          end
        end
        ST_CAPTURE: begin
          if (din_valid) begin
            cap_s     = 1'b1;
            state_n_s = last_s ? ST_DONE : ST_CAPTURE;
          end else begin
            state_n_s = ST_CAPTURE;
          end
        end
        default: state_n_s = ST_IDLE;
      endcase
    end
  end

  // State register, arm edge detect and decoded status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      arm_d_r  <= 1'b0;
      arm_ok_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_n_s;
      arm_d_r  <= ctrl_arm;
      arm_ok_r <= arm_ok_r | ~ctrl_arm;
      busy_r   <= (state_n_s == ST_ARMED) || (state_n_s == ST_CAPTURE);
      done_r   <= (state_n_s == ST_DONE);
    end
  end

  // Capture counters and latched length; the address counter wraps only on a full-depth run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r      <= DEPTH_C;
      addr_cnt_r <= {ADDR_W{1'b0}};
      wr_count_r <= {(ADDR_W+1){1'b0}};
    end else if (load_s) begin
      len_r      <= len_sel_s;
      addr_cnt_r <= {ADDR_W{1'b0}};
      wr_count_r <= {(ADDR_W+1){1'b0}};
    end else if (cap_s) begin
      addr_cnt_r <= addr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      wr_count_r <= wr_count_r + ONE_C;
    end
  end

  // BRAM write port register; address and data hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_we_r      <= 1'b0;
      bram_addr_r    <= {ADDR_W{1'b0}};
      bram_wr_data_r <= {DATA_W{1'b0}};
    end else begin
      bram_we_r <= cap_s;
      if (cap_s) begin
        bram_addr_r    <= addr_cnt_r;
        bram_wr_data_r <= din;
      end
    end
  end

  assign bram_we      = bram_we_r;
  assign bram_addr    = bram_addr_r;
  assign bram_wr_data = bram_wr_data_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign wr_count     = wr_count_r;

endmodule

// File: doc/bram_snap_ctrl.md
Name: bram_snap_ctrl

Overview:
- Snapshot capture controller that drives the fabric-side port of the shared dual-port BRAM: bram_we, bram_addr and bram_wr_data.
- Arms on request and waits for an optional trigger. It then writes a programmed number of valid input words into consecutive BRAM addresses starting at 0, and flags completion.
- The processor reads the captured words over the bus-side BRAM port. Status (busy/done/word count) goes to a software register.

Parameters:
- ADDR_W, 10, BRAM fabric-port address width in words; depth = 2^ADDR_W.
- DATA_W, 32, data width of the BRAM fabric port and of din.

Ports:
- clk  in  1  single clock for all logic; also the BRAM port-A clock.
- rst_n  in  1  asynchronous active-low reset.
- ctrl_arm  in  1  rising-edge arm request; internally edge-detected.
- ctrl_abort  in  1  level; forces the block to IDLE.
- ctrl_trig_en  in  1  1 = wait for trig; 0 = start on arm. Sampled on the arm edge.
- ctrl_len  in  ADDR_W+1  words to capture; 0 or any value above 2^ADDR_W means 2^ADDR_W. Sampled on the arm edge.
- trig  in  1  capture trigger, level-sampled.
- din_valid  in  1  input word qualifier.
- din  in  DATA_W  input data.
- bram_we  out  1  BRAM write enable, registered.
- bram_addr  out  ADDR_W  BRAM word address, registered.
- bram_wr_data  out  DATA_W  BRAM write data, registered.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE.
- wr_count  out  ADDR_W+1  words written in the current or last capture.

Behaviour:
- Reset (async assert, sync release): state=IDLE.
  - All outputs are 0: bram_we, bram_addr, bram_wr_data, busy, done, wr_count.
  - The arm edge-detect register is cleared.
- States: IDLE, ARMED, CAPTURE, DONE. State is registered; busy and done decode from it.
- arm_pulse = ctrl_arm & ~ctrl_arm_d.
- IDLE or DONE, on arm_pulse:
  - Latch len_q (0 or >2^ADDR_W → 2^ADDR_W) and trig_en_q.
  - Clear wr_count and the address counter.
  - Go to ARMED if ctrl_trig_en=1, else CAPTURE.
- ARMED: on trig=1, go to CAPTURE.
  - If din_valid=1 in that same cycle, that word is captured to address 0.
  - Trigger is only sampled in ARMED. A trig in the arm_pulse cycle is ignored.
- CAPTURE: each cycle with din_valid=1:
  - Next cycle: bram_we=1, bram_addr=addr_cnt, bram_wr_data=din.
  - addr_cnt++ and wr_count++.
  - din_valid=0 stalls: bram_we=0 next cycle; bram_addr and bram_wr_data hold.
- Write count reaching len_q: the state becomes DONE in the same cycle the last write is presented.
  - No further writes follow; din_valid is ignored.
  - addr_cnt wraps to 0 only when len=2^ADDR_W. No address ever exceeds len_q-1.
- Latency: din to bram_we/bram_wr_data is exactly 1 cycle.
- DONE: holds done=1 and wr_count=len_q until the next arm_pulse. Re-arm from DONE is legal.
- arm_pulse while ARMED or CAPTURE: ignored.
- ctrl_abort=1 in any state:
  - Next state is IDLE and bram_we=0 next cycle. A write already registered this cycle completes.
  - wr_count holds its value; done=0.
  - Abort has priority over arm_pulse and over trig in the same cycle.
- Simultaneous trig and last word: not possible in ARMED unless len=1. With len=1, ARMED+trig+din_valid → one write, then DONE.
- ctrl_len and ctrl_trig_en changes after arming have no effect until the next arm.

Test Plan:
- Free-run: ctrl_trig_en=0, ctrl_len=4, arm, din_valid=1 with din=0xA0..0xA5 → writes 0xA0..0xA3 to addr 0..3. Write to addr 0 occurs 1 cycle after the first valid; done=1 and wr_count=4; no write of 0xA4.
- Triggered capture: ctrl_trig_en=1, len=3, din counting from 0x10 every cycle, trig at din=0x15 → addr0=0x15, addr1=0x16, addr2=0x17; busy=1 from the arm edge until DONE.
- Stalls: len=3, din_valid pattern 1,0,0,1,0,1 → exactly 3 writes to consecutive addresses with bram_we gaps matching; wr_count steps 1,2,3.
- Full depth: ctrl_len=0 (ADDR_W=10) → 1024 writes to addr 0..1023, then done=1 and wr_count=1024. ctrl_len=2000 gives the identical result.
- Abort: abort in CAPTURE after 5 writes → IDLE next cycle, no further bram_we, done=0, wr_count=5. Re-arm then restarts at addr 0.
- Async reset mid-capture: rst_n low between clock edges → all outputs 0 immediately. After release, ctrl_arm held high from before reset produces no capture until it toggles low then high.
